// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the RAM arbiter slice.
package ram_arbiter_pkg;

  // Top-level FSM: sweep the RAM with the clear value, then serve requesters.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_CLEAR_VALUE = 0;

  // Requester indices inside the two-bit req/gnt vectors.
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant pointer and an enable gate.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last_b
);

  logic last_b_q;

  // One-hot grant: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_b_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer starts at "B granted last" so A wins the first tie; it only moves on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_b_q <= gnt[1];
    end
  end

  assign last_b = last_b_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM (sync write, combinational read) between a CPU
// port (A) and a loader port (B), after an optional clear sweep.
//
// Handshake on each port: the requester raises x_req together with x_we,
// x_addr and x_wdata and holds all of them stable until x_gnt is seen high in
// the same cycle; the access is taken at the clock edge that ends that cycle.
// A granted read returns x_rdata with a one-cycle x_rvalid pulse in the next
// cycle; x_rdata then holds until that port's next granted read.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = DATA_WIDTH'(DEF_CLEAR_VALUE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;
  localparam state_t                ST_INIT  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_next;
  logic [1:0]            req, gnt;
  logic                  arb_en;
  logic                  last_b;
  logic                  a_rvalid_q, b_rvalid_q;

  // FSM and sweep counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Next state: step through every address once, leave CLEAR after the last word.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    unique case (state)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Grants are withheld while clearing and while reset is held, so nothing
  // is committed in a reset cycle.
  assign arb_en         = (state == ST_RUN) && !reset;
  assign req[PORT_A]    = a_req;
  assign req[PORT_B]    = b_req;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (arb_en),
    .req    (req),
    .gnt    (gnt),
    .last_b (last_b)
  );

  assign a_gnt = gnt[PORT_A];
  assign b_gnt = gnt[PORT_B];

  // RAM pin mux: sweep writes while clearing, otherwise the granted port; idle drives zeros.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram_address = clr_cnt;
        ram_in      = CLEAR_VALUE;
        ram_load    = 1'b1;
      end else if (a_gnt) begin
        ram_address = a_addr;
        ram_in      = a_wdata;
        ram_load    = a_we;
      end else if (b_gnt) begin
        ram_address = b_addr;
        ram_in      = b_wdata;
        ram_load    = b_we;
      end
    end
  end

  // Read return: capture ram_out at the edge ending a granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata    <= '0;
      b_rdata    <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_gnt && !a_we;
      b_rvalid_q <= b_gnt && !b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= ram_out;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= ram_out;
      end
    end
  end

  // A reset arriving while a read result is on its way discards it immediately.
  assign a_rvalid  = a_rvalid_q && !reset;
  assign b_rvalid  = b_rvalid_q && !reset;
  assign busy      = (state == ST_CLEAR);
  assign dbg_state = state;

  // The pointer is only observed through arbitration order.
  logic unused_ok;
  assign unused_ok = last_b;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 256x16 RAM attached.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in, ram_out;
  logic          ram_load, busy;
  state_t        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [256];

  // Clock block.
  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rdata     (a_rdata),
    .a_rvalid    (a_rvalid),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rdata     (b_rdata),
    .b_rvalid    (b_rvalid),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // RAM model: synchronous write, combinational read.
  assign ram_out = mem[ram_address];
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    step();
    step();

    // Reset state.
    chk("rst_busy", 32'(busy), 1);
    chk("rst_a_rdata", 32'(a_rdata), 0);
    chk("rst_b_rdata", 32'(b_rdata), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_ram_load", 32'(ram_load), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_CLEAR));

    // Clear sweep; A asks to read 0x7F from sweep cycle 10 onward.
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) begin
        a_req = 1; a_we = 0; a_addr = 8'h7F;
      end
      #1;
      chk("clr_busy", 32'(busy), 1);
      chk("clr_load", 32'(ram_load), 1);
      chk("clr_addr", 32'(ram_address), 32'(i));
      chk("clr_in", 32'(ram_in), 0);
      chk("clr_a_gnt", 32'(a_gnt), 0);
      step();
    end

    // First RUN cycle: pending A read granted at once.
    #1;
    chk("run_busy", 32'(busy), 0);
    chk("run_state", 32'(dbg_state), 32'(ST_RUN));
    chk("pend_a_gnt", 32'(a_gnt), 1);
    chk("pend_addr", 32'(ram_address), 32'h7F);
    chk("pend_load", 32'(ram_load), 0);
    step();
    a_req = 0;
    #1;
    chk("r7f_rvalid", 32'(a_rvalid), 1);
    chk("r7f_rdata", 32'(a_rdata), 0);

    // Preload: A writes 0x01 <- 0x1111, then B writes 0x02 <- 0x2222.
    a_req = 1; a_we = 1; a_addr = 8'h01; a_wdata = 16'h1111;
    #1;
    chk("pre_a_gnt", 32'(a_gnt), 1);
    step();
    a_req = 0;
    b_req = 1; b_we = 1; b_addr = 8'h02; b_wdata = 16'h2222;
    #1;
    chk("pre_a_norv", 32'(a_rvalid), 0);
    chk("pre_b_gnt", 32'(b_gnt), 1);
    chk("pre_b_load", 32'(ram_load), 1);
    step();
    b_req = 0;

    // A writes 0x10 <- 0x1234 while B reads 0x10.
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 16'h1234;
    b_req = 1; b_we = 0; b_addr = 8'h10;
    #1;
    chk("wr_a_gnt", 32'(a_gnt), 1);
    chk("wr_b_gnt", 32'(b_gnt), 0);
    chk("wr_load", 32'(ram_load), 1);
    chk("wr_addr", 32'(ram_address), 32'h10);
    chk("wr_in", 32'(ram_in), 32'h1234);
    step();
    a_req = 0;
    #1;
    chk("rd_b_gnt", 32'(b_gnt), 1);
    chk("rd_a_gnt", 32'(a_gnt), 0);
    chk("rd_a_norv", 32'(a_rvalid), 0);
    chk("rd_load", 32'(ram_load), 0);
    step();
    b_req = 0;
    #1;
    chk("rd_b_rvalid", 32'(b_rvalid), 1);
    chk("rd_b_rdata", 32'(b_rdata), 32'h1234);
    chk("idle_gnt", 32'({a_gnt, b_gnt}), 0);
    chk("idle_load", 32'(ram_load), 0);
    chk("idle_addr", 32'(ram_address), 0);
    chk("idle_in", 32'(ram_in), 0);

    // Contention: A reads 0x01, B reads 0x02, both held for 6 cycles.
    a_req = 1; a_we = 0; a_addr = 8'h01;
    b_req = 1; b_we = 0; b_addr = 8'h02;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_a_gnt", 32'(a_gnt), 32'(k % 2 == 0));
      chk("cont_b_gnt", 32'(b_gnt), 32'(k % 2 == 1));
      if (k > 0) begin
        chk("cont_a_rv", 32'(a_rvalid), 32'(k % 2 == 1));
        chk("cont_b_rv", 32'(b_rvalid), 32'(k % 2 == 0));
        chk("cont_a_rd", 32'(a_rdata), 32'h1111);
      end
      if (k > 1) chk("cont_b_rd", 32'(b_rdata), 32'h2222);
      step();
    end
    a_req = 0; b_req = 0;
    #1;
    chk("cont_end_b_rv", 32'(b_rvalid), 1);
    chk("cont_end_a_rv", 32'(a_rvalid), 0);
    chk("cont_end_b_rd", 32'(b_rdata), 32'h2222);

    // B alone: four back-to-back writes 0x20..0x23 <- 0xA0..0xA3.
    for (int j = 0; j < 4; j++) begin
      b_req = 1; b_we = 1; b_addr = AW'(8'h20 + j); b_wdata = DW'(16'h00A0 + j);
      #1;
      chk("bw_gnt", 32'(b_gnt), 1);
      chk("bw_addr", 32'(ram_address), 32'(8'h20 + j));
      step();
    end
    b_req = 0;

    // A reads them back-to-back.
    for (int j = 0; j < 4; j++) begin
      a_req = 1; a_we = 0; a_addr = AW'(8'h20 + j);
      #1;
      chk("ar_gnt", 32'(a_gnt), 1);
      step();
      chk("ar_rvalid", 32'(a_rvalid), 1);
      chk("ar_rdata", 32'(a_rdata), 32'(16'h00A0 + j));
    end
    a_req = 0;

    // Read grant, then reset in the next cycle (with an A write offered).
    a_req = 1; a_we = 0; a_addr = 8'h20;
    #1;
    chk("rr_a_gnt", 32'(a_gnt), 1);
    step();
    reset = 1'b1;
    a_req = 1; a_we = 1; a_addr = 8'h55; a_wdata = 16'hBEEF;
    #1;
    chk("rr_rv_forced", 32'(a_rvalid), 0);
    chk("rr_wr_gnt", 32'(a_gnt), 0);
    chk("rr_wr_load", 32'(ram_load), 0);
    step();
    a_req = 0;
    #1;
    chk("rr2_busy", 32'(busy), 1);
    chk("rr2_rvalid", 32'(a_rvalid), 0);
    chk("rr2_rdata", 32'(a_rdata), 0);
    reset = 1'b0;
    #1;
    chk("rs_addr0", 32'(ram_address), 0);
    chk("rs_load", 32'(ram_load), 1);
    chk("rs_busy", 32'(busy), 1);
    step();
    #1;
    chk("rs_addr1", 32'(ram_address), 1);

    // Let the second sweep finish, within a cycle budget.
    begin
      int cyc = 0;
      while (busy && cyc < 400) begin
        step();
        cyc++;
      end
      chk("clear2_done", 32'(busy), 0);
      chk("clear2_len", 32'(cyc), 255);
    end

    // Old contents wiped by the second sweep.
    b_req = 1; b_we = 0; b_addr = 8'h10;
    #1;
    chk("post_b_gnt", 32'(b_gnt), 1);
    step();
    b_req = 0;
    #1;
    chk("post_b_rv", 32'(b_rvalid), 1);
    chk("post_b_rd", 32'(b_rdata), 0);
    chk("post_mem55", 32'(mem[8'h55]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 256x16 data RAM (sync write, combinational read) between two requesters: port A (CPU) and port B (loader/DMA).
- After reset, an optional clear sequencer writes CLEAR_VALUE to every word before granting any access.
- Grants at most one access per cycle using round-robin arbitration.
- Sits between the requesters and the RAM's address/in/load/out pins.

Parameters:
- ADDR_WIDTH, 8, RAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16, RAM word width.
- CLEAR_ON_RESET, 1, if 1, run the clear sweep after reset; if 0, go straight to RUN.
- CLEAR_VALUE, 0, word written during the clear sweep.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  port A access request; held with a_we/a_addr/a_wdata until a_gnt.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  ADDR_WIDTH  port A address.
- a_wdata  input  DATA_WIDTH  port A write data.
- a_gnt  output  1  access accepted this cycle (combinational).
- a_rdata  output  DATA_WIDTH  registered read data.
- a_rvalid  output  1  one-cycle pulse: a_rdata updated.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as the port A signals, for port B.
- ram_address  output  ADDR_WIDTH  to RAM address.
- ram_in  output  DATA_WIDTH  to RAM in.
- ram_load  output  1  to RAM load.
- ram_out  input  DATA_WIDTH  from RAM out.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (sampled on clk edge):
  - State CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_cnt=0, busy=CLEAR_ON_RESET.
  - a_gnt=b_gnt=0; a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
  - Priority pointer = B-last, so A wins the first tie.
- CLEAR state:
  - ram_address=clr_cnt, ram_in=CLEAR_VALUE, ram_load=1 every cycle; clr_cnt increments each cycle.
  - Occupies exactly 2^ADDR_WIDTH cycles.
  - On the cycle clr_cnt=2^ADDR_WIDTH-1: write the final word, then go to RUN. busy is 0 from the first RUN cycle.
  - No grants are issued; incoming requests stay pending.
- RUN state, per cycle:
  - Only A requests -> A granted.
  - Only B requests -> B granted.
  - Both request -> the port not granted most recently wins.
  - Pointer updates only on a grant.
  - Winner drives ram_address=x_addr, ram_in=x_wdata, ram_load=x_we; x_gnt=1 combinationally in the same cycle.
- Write: committed at the grant-cycle edge; no rvalid.
- Read: ram_out is captured into x_rdata at the grant-cycle edge; x_rvalid=1 for exactly the next cycle (latency 1).
  - x_rdata holds its value until that port's next granted read.
- No request: ram_load=0, ram_address=0, ram_in=0, both gnt=0.
- Back-to-back grants to one port are allowed (throughput 1/cycle when uncontested).
- Under continuous contention each port gets every other cycle; worst-case wait is 1 cycle.
- Write on cycle N followed by a read of the same address on cycle N+1 (either port) returns the new data.
- Same-cycle conflict cannot occur: only one port is granted per cycle.
- Reset mid-operation (CLEAR or RUN):
  - Pending read results are discarded (rvalid forced 0).
  - The clear sweep restarts from address 0.
  - A write granted in the reset cycle is not performed: ram_load=0 during reset.
- Requesters must not change addr/we/wdata while req=1 and gnt=0; behaviour otherwise is undefined.

Decomposition:
- Shared header/package: state encodings (ST_CLEAR, ST_RUN), the ADDR_WIDTH/DATA_WIDTH defaults, and the CLEAR_VALUE default.
- One sub-module: rr_arbiter2.
  - Inputs: clk, reset, req[1:0].
  - Outputs: gnt[1:0] (one-hot, combinational).
  - Holds the last-grant pointer register.
  - Enable input gates grants off during CLEAR.
- The top level holds the clear FSM/counter, the RAM mux and the read-return registers.

Test Plan:
- Reset with CLEAR_ON_RESET=1, no requests.
  - Required: busy=1 for exactly 256 cycles; ram_load=1 with ram_address 0..255 in order; then busy=0.
  - A read of address 0x7F afterwards returns 0x0000.
- After the clear, A writes 0x1234 to 0x10 and B simultaneously requests a read of 0x10.
  - Required: a_gnt in cycle N; b_gnt in N+1; b_rvalid in N+2 with b_rdata=0x1234.
- A and B both hold req (reads of 0x01 and 0x02) for 6 cycles.
  - Required: grant order A,B,A,B,A,B; each rvalid one cycle after its grant; data matches the preloaded contents.
- B alone issues 4 consecutive writes (0x20..0x23 <- 0xA0..0xA3), then A reads each address.
  - Required: b_gnt on 4 consecutive cycles; A reads return 0xA0..0xA3.
- A requests during the clear sweep (cycle 10).
  - Required: a_gnt stays 0 until the first RUN cycle, then is granted immediately.
- Reset asserted the cycle after a read grant.
  - Required: a_rvalid stays 0; busy=1; ram_address restarts at 0 on the following cycle.
